pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised pipeline-stage register with a valid/ready handshake. It is the successor to the fixed-field decode/execute style registers.
- Carries one opaque payload vector of DATA_W bits. Stage-specific fields are packed and unpacked by the instantiating stage.
- Optional two-entry skid buffer, so the upstream ready signal is registered and does not depend combinationally on downstream ready. This breaks the stall path from the cache back through decode.
- Sits between any two Otter pipeline stages (F/D, D/E, E/M, M/W). Includes a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, payload width in bits (min 1).
- SKID, 1. 1 = two-entry skid buffer with registered in_ready. 0 = single register with combinational in_ready.
- FLUSH_VAL, '0, value loaded into out_data on reset or flush (a NOP/bubble encoding).
- CNT_W, 16, width of the stall counter (min 1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries (branch/jump squash).
- in_valid  in  1  upstream has a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage accepts in_data this cycle.
- out_valid  out  1  out_data is a valid payload.
- out_data  out  DATA_W  head payload.
- out_ready  in  1  downstream consumes out_data this cycle.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Priority per cycle: RST > flush > handshake.
- RST (synchronous): state=EMPTY, out_valid=0, out_data=FLUSH_VAL, skid entry=FLUSH_VAL, stall_cnt=0, in_ready=1 (SKID=1).
- flush:
  - Same as RST, except stall_cnt is retained.
  - Any in_data presented in the flush cycle is dropped, even if in_ready=1.
  - Reset or flush in the FULL state discards both entries.
- SKID=1 state machine (main register = out_data; skid register = second entry):
  - EMPTY (out_valid=0, in_ready=1): in_valid -> main<=in_data, go to BUSY; otherwise stay.
  - BUSY (out_valid=1, in_ready=1):
    - in_valid & out_ready -> main<=in_data, stay in BUSY (full throughput, 1 per cycle).
    - in_valid & !out_ready -> skid<=in_data, go to FULL.
    - !in_valid & out_ready -> go to EMPTY.
    - Otherwise hold.
  - FULL (out_valid=1, in_ready=0): out_ready -> main<=skid, go to BUSY; otherwise hold. No input is accepted in FULL.
  - in_ready is a flop equal to (next_state != FULL).
- SKID=0 behaviour:
  - States EMPTY/BUSY only. in_ready = out_ready | !out_valid (combinational).
  - When in_ready & in_valid, main<=in_data next cycle.
  - When out_ready & !in_valid, out_valid<=0.
- Latency: 1 cycle from accepted input to out_valid in all modes. Ordering is strictly FIFO, with no loss or duplication.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 (no wrap). Cleared only by RST.
- out_data in EMPTY holds its last value or FLUSH_VAL; consumers must qualify it with out_valid.

Decomposition:
- Shared package otter_pipe_pkg:
  - typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_t.
  - Default bubble constant NOP_INSTR = 32'h00000013.
  - Optional packed struct typedefs for the per-stage payloads (de_payload_t, em_payload_t), so stages can size DATA_W with $bits().
- Sub-module sat_counter (parameter W; inputs CLK, RST, inc; output cnt) holds the stall counter and is reusable for cache hit/miss counters.
- The FSM and data path stay in one module, selected by a generate on SKID.

Test Plan:
- Reset: assert RST 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=FLUSH_VAL, stall_cnt=0, in_ready=1; nothing is captured.
- Streaming: out_ready=1, send 8'h01..8'h08 on consecutive cycles -> outputs 01..08 appear on out_data one cycle after each input, out_valid continuous, in_ready always 1.
- Back-pressure (SKID=1):
  - In BUSY holding A=5, drop out_ready and send B=6 -> FULL, in_ready=0 next cycle, out_data stays 5.
  - Raise out_ready -> 5 consumed, then 6; stall_cnt increments once per blocked cycle.
- Flush while FULL: entries 0x11 and 0x22 held, assert flush with in_valid=1, in_data=0x33 -> next cycle EMPTY, out_valid=0, out_data=FLUSH_VAL, 0x33 dropped, stall_cnt unchanged.
- Saturation: CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt reaches 7 and stays at 7.
- SKID=0 mode: out_ready=0 while BUSY -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 in the same cycle -> new data is loaded, in_ready=1.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for Otter pipeline-stage registers.
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  rd;
    logic        reg_wr;
  } de_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_we;
    logic        mem_rd;
  } em_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer
// (registered in_ready) and a saturating stall-cycle counter.
module pipe_stage_skid_reg
  import otter_pipe_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter bit                 SKID      = 1'b1,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  if (SKID) begin : g_skid
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
        main_d  = FLUSH_VAL;
        skid_d  = FLUSH_VAL;
      end else begin
        unique case (state_q)
          EMPTY: if (in_valid) begin
            main_d  = in_data;
            state_d = BUSY;
          end
          BUSY: begin
            if (in_valid && out_ready) begin
              main_d = in_data;
            end else if (in_valid) begin
              skid_d  = in_data;
              state_d = FULL;
            end else if (out_ready) begin
              state_d = EMPTY;
            end
          end
          FULL: if (out_ready) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    // in_ready is a flop so upstream never sees out_ready combinationally
    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q    <= EMPTY;
        main_q     <= FLUSH_VAL;
        skid_q     <= FLUSH_VAL;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        main_q     <= main_d;
        skid_q     <= skid_d;
        in_ready_q <= (state_d != FULL);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    assign in_ready = out_ready | ~out_valid;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush) begin
        state_d = EMPTY;
        main_d  = FLUSH_VAL;
      end else if (in_ready && in_valid) begin
        main_d  = in_data;
        state_d = BUSY;
      end else if (out_ready) begin
        state_d = EMPTY;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= EMPTY;
        main_q  <= FLUSH_VAL;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench: skid instance (A), 3-bit counter instance (B), no-skid instance (C).
module tb_pipe_stage_skid_reg;
  import otter_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];

  // A: SKID=1, 32-bit, bubble = NOP
  logic        a_rst, a_flush, a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_id, a_od;
  logic [15:0] a_cnt;
  pipe_stage_skid_reg #(.DATA_W(32), .SKID(1'b1), .FLUSH_VAL(NOP_INSTR), .CNT_W(16)) dut_a (
    .CLK(clk), .RST(a_rst), .flush(a_flush), .in_valid(a_iv), .in_data(a_id),
    .in_ready(a_ir), .out_valid(a_ov), .out_data(a_od), .out_ready(a_or), .stall_cnt(a_cnt));

  // B: SKID=1, 3-bit counter for saturation
  logic       b_rst, b_flush, b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_id, b_od;
  logic [2:0] b_cnt;
  pipe_stage_skid_reg #(.DATA_W(8), .SKID(1'b1), .FLUSH_VAL(8'h00), .CNT_W(3)) dut_b (
    .CLK(clk), .RST(b_rst), .flush(b_flush), .in_valid(b_iv), .in_data(b_id),
    .in_ready(b_ir), .out_valid(b_ov), .out_data(b_od), .out_ready(b_or), .stall_cnt(b_cnt));

  // C: SKID=0
  logic       c_rst, c_flush, c_iv, c_ir, c_ov, c_or;
  logic [7:0] c_id, c_od;
  logic [3:0] c_cnt;
  pipe_stage_skid_reg #(.DATA_W(8), .SKID(1'b0), .FLUSH_VAL(8'h00), .CNT_W(4)) dut_c (
    .CLK(clk), .RST(c_rst), .flush(c_flush), .in_valid(c_iv), .in_data(c_id),
    .in_ready(c_ir), .out_valid(c_ov), .out_data(c_od), .out_ready(c_or), .stall_cnt(c_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_iv = 1'b1; a_id = 32'hDEADBEEF; a_or = 1'b1;
    b_rst = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_id = 8'h00; b_or = 1'b0;
    c_rst = 1'b1; c_flush = 1'b0; c_iv = 1'b0; c_id = 8'h00; c_or = 1'b0;

    // Monitor: every output transfer of A must match the scoreboard head
    fork
      forever begin
        @(negedge clk);
        if (!a_rst && !a_flush && a_ov === 1'b1 && a_or === 1'b1) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got %h expected no transfer", a_od);
          end else begin
            chk("sb_data", a_od, sb.pop_front());
          end
        end
      end
    join_none

    // Reset held 2 cycles with live input
    step();
    step();
    chk("rst_out_valid", {31'b0, a_ov}, 32'd0);
    chk("rst_out_data", a_od, NOP_INSTR);
    chk("rst_stall_cnt", {16'b0, a_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, a_ir}, 32'd1);
    a_rst = 1'b0; a_iv = 1'b0;
    step();
    chk("rst_nocapture", {31'b0, a_ov}, 32'd0);

    // Streaming 1..8 at full throughput
    a_or = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_iv = 1'b1; a_id = 32'(i);
      chk("stream_in_ready", {31'b0, a_ir}, 32'd1);
      sb.push_back(32'(i));
      step();
      chk("stream_lat_valid", {31'b0, a_ov}, 32'd1);
      chk("stream_lat_data", a_od, 32'(i));
    end
    a_iv = 1'b0;
    step();
    chk("stream_drain", {31'b0, a_ov}, 32'd0);
    chk("stream_no_stall", {16'b0, a_cnt}, 32'd0);

    // Back-pressure into the skid entry
    a_or = 1'b0; a_iv = 1'b1; a_id = 32'd5; sb.push_back(32'd5);
    step();
    a_id = 32'd6; sb.push_back(32'd6);
    chk("bp_busy_ready", {31'b0, a_ir}, 32'd1);
    step();
    a_iv = 1'b0;
    chk("bp_full_ready", {31'b0, a_ir}, 32'd0);
    chk("bp_hold_data", a_od, 32'd5);
    chk("bp_cnt1", {16'b0, a_cnt}, 32'd1);
    step();
    chk("bp_hold_data2", a_od, 32'd5);
    chk("bp_cnt2", {16'b0, a_cnt}, 32'd2);
    a_or = 1'b1;
    step();
    chk("bp_second", a_od, 32'd6);
    chk("bp_ready_back", {31'b0, a_ir}, 32'd1);
    step();
    chk("bp_empty", {31'b0, a_ov}, 32'd0);
    chk("bp_cnt_kept", {16'b0, a_cnt}, 32'd2);

    // Flush while FULL drops both entries and the flush-cycle input
    a_or = 1'b0; a_iv = 1'b1; a_id = 32'h11; sb.push_back(32'h11);
    step();
    a_id = 32'h22; sb.push_back(32'h22);
    step();
    chk("fl_full", {31'b0, a_ir}, 32'd0);
    chk("fl_cnt_pre", {16'b0, a_cnt}, 32'd3);
    a_flush = 1'b1; a_id = 32'h33; a_or = 1'b1;
    sb.delete();
    step();
    a_flush = 1'b0; a_iv = 1'b0;
    chk("fl_valid", {31'b0, a_ov}, 32'd0);
    chk("fl_data", a_od, NOP_INSTR);
    chk("fl_in_ready", {31'b0, a_ir}, 32'd1);
    chk("fl_cnt_kept", {16'b0, a_cnt}, 32'd3);
    step();
    chk("fl_dropped", {31'b0, a_ov}, 32'd0);
    a_iv = 1'b1; a_id = 32'h44; sb.push_back(32'h44);
    step();
    a_iv = 1'b0;
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Saturation on a 3-bit counter
    step();
    b_rst = 1'b0; b_iv = 1'b1; b_id = 8'hA5;
    step();
    b_iv = 1'b0;
    chk("sat_start", {29'b0, b_cnt}, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("sat_cnt", {29'b0, b_cnt}, (k < 7) ? 32'(k) : 32'd7);
    end
    chk("sat_data_held", {24'b0, b_od}, 32'hA5);

    // SKID=0: combinational in_ready
    c_rst = 1'b0; c_iv = 1'b1; c_id = 8'hA1; c_or = 1'b0;
    #1;
    chk("ns_empty_ready", {31'b0, c_ir}, 32'd1);
    step();
    c_id = 8'hA2;
    chk("ns_busy_valid", {31'b0, c_ov}, 32'd1);
    chk("ns_busy_stall_ready", {31'b0, c_ir}, 32'd0);
    step();
    chk("ns_held", {24'b0, c_od}, 32'hA1);
    c_or = 1'b1;
    #1;
    chk("ns_same_cycle_ready", {31'b0, c_ir}, 32'd1);
    step();
    chk("ns_loaded", {24'b0, c_od}, 32'hA2);
    chk("ns_loaded_valid", {31'b0, c_ov}, 32'd1);
    c_iv = 1'b0;
    step();
    chk("ns_empty", {31'b0, c_ov}, 32'd0);
    chk("ns_cnt", {28'b0, c_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
